// File: rtl/track_sequencer.sv
// Playback controller for the PWM music player: debounces play/next buttons and
// sequences tracks through an IDLE/START/PLAYING/PAUSED/GAP state machine.
module track_sequencer #(
    parameter int NUM_TRACKS      = 4,
    parameter int TRACK_STRIDE    = 1024,
    parameter int ADDR_WIDTH      = 12,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GAP_CYCLES      = 25000000,
    parameter bit LOOP            = 1'b1,
    localparam int IDX_W          = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_play,
    input  logic                  btn_next,
    input  logic                  player_done,
    output logic                  track_start,
    output logic [ADDR_WIDTH-1:0] track_base,
    output logic                  player_enable,
    output logic [IDX_W-1:0]      track_index,
    output logic [3:0]            led
);

    localparam int DB_W  = ($clog2(DEBOUNCE_CYCLES + 1) > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int GAP_W = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TRACKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PLAYING,
        PAUSED,
        GAP
    } state_t;

    // Button input path; bit 0 = play, bit 1 = next.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign btn_raw = {btn_next, btn_play};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_cnt[i] <= '0;
                        level[i]  <= sync2[i];
                        press[i]  <= sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic play_evt;
    logic next_evt;

    assign play_evt = press[0];
    assign next_evt = press[1];

    function automatic logic [IDX_W-1:0] advance(input logic [IDX_W-1:0] idx);
        if (idx == IDX_LAST) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    function automatic logic [3:0] led_of(input state_t s);
        case (s)
            IDLE:          return 4'b0001;
            START,
            PLAYING:       return 4'b0010;
            PAUSED:        return 4'b0100;
            GAP:           return 4'b1000;
            default:       return 4'b0001;
        endcase
    endfunction

    state_t                state;
    state_t                state_n;
    logic [IDX_W-1:0]      idx_n;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_n;
    logic [ADDR_WIDTH-1:0] base_n;

    // Transition logic; outputs are registered from the next state so they
    // change on the same edge as state, index and base.
    always_comb begin
        state_n = state;
        idx_n   = track_index;
        gap_n   = gap_cnt;
        case (state)
            IDLE: begin
                if (next_evt) begin
                    idx_n = advance(track_index);
                end else if (play_evt) begin
                    state_n = START;
                end
            end
            START: begin
                state_n = PLAYING;
            end
            PLAYING: begin
                if (next_evt) begin
                    idx_n   = advance(track_index);
                    state_n = START;
                end else if (player_done) begin
                    gap_n   = '0;
                    state_n = GAP;
                end else if (play_evt) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (next_evt) begin
                    idx_n   = advance(track_index);
                    state_n = START;
                end else if (play_evt) begin
                    state_n = PLAYING;
                end
            end
            GAP: begin
                if (next_evt) begin
                    idx_n   = advance(track_index);
                    state_n = START;
                end else if (gap_cnt == GAP_LAST) begin
                    if (!LOOP && (track_index == IDX_LAST)) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n   = advance(track_index);
                        state_n = START;
                    end
                end else if (play_evt) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        base_n = ADDR_WIDTH'(idx_n) * ADDR_WIDTH'(TRACK_STRIDE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            track_index   <= '0;
            gap_cnt       <= '0;
            track_base    <= '0;
            track_start   <= 1'b0;
            player_enable <= 1'b0;
            led           <= 4'b0001;
        end else begin
            state         <= state_n;
            track_index   <= idx_n;
            gap_cnt       <= gap_n;
            track_base    <= base_n;
            track_start   <= (state_n == START);
            player_enable <= (state_n == START) || (state_n == PLAYING);
            led           <= led_of(state_n);
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Bench for track_sequencer: scoreboard of expected track starts plus a table of
// button/done actions and hand-written timing sequences; a LOOP=0 copy shares inputs.
module tb_track_sequencer;

    localparam int NT     = 3;
    localparam int STRIDE = 256;
    localparam int DB     = 4;
    localparam int GAPC   = 10;

    localparam int A_PLAY     = 0;
    localparam int A_NEXT     = 1;
    localparam int A_DONE     = 2;
    localparam int A_NEXTDONE = 3;
    localparam int A_GAPWAIT  = 4;

    logic        clk;
    logic        reset;
    logic        btn_play;
    logic        btn_next;
    logic        player_done;

    logic        ts1, en1, ts0, en0;
    logic [11:0] base1, base0;
    logic [1:0]  idx1, idx0;
    logic [3:0]  led1, led0;

    track_sequencer #(
        .NUM_TRACKS(NT), .TRACK_STRIDE(STRIDE), .ADDR_WIDTH(12),
        .DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAPC), .LOOP(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .btn_play(btn_play), .btn_next(btn_next),
        .player_done(player_done), .track_start(ts1), .track_base(base1),
        .player_enable(en1), .track_index(idx1), .led(led1)
    );

    track_sequencer #(
        .NUM_TRACKS(NT), .TRACK_STRIDE(STRIDE), .ADDR_WIDTH(12),
        .DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAPC), .LOOP(1'b0)
    ) dut_noloop (
        .clk(clk), .reset(reset), .btn_play(btn_play), .btn_next(btn_next),
        .player_done(player_done), .track_start(ts0), .track_base(base0),
        .player_enable(en0), .track_index(idx0), .led(led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] base;
    } exp_t;

    typedef struct {
        int         act;
        logic [3:0] led;
        int         idx;
        logic       en;
        bit         start;
    } step_t;

    exp_t  sbq[$];
    step_t steps[16];
    int    tests;
    int    fails;
    int    starts0;
    logic  prev_ts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_start(input int i);
        exp_t e;
        e.idx  = 2'(i);
        e.base = 12'(i * STRIDE);
        sbq.push_back(e);
    endtask

    // One clock; samples 1 time unit after the edge and scores any track_start.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (ts1) begin
            check("start_not_b2b", 32'(prev_ts), 0);
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_start: got idx %0d base %0d, required no start", idx1, base1);
            end else begin
                e = sbq.pop_front();
                check("start_idx", 32'(idx1), 32'(e.idx));
                check("start_base", 32'(base1), 32'(e.base));
                check("start_enable", 32'(en1), 1);
            end
        end
        prev_ts = ts1;
        if (ts0) starts0++;
    endtask

    task automatic do_reset();
        check("sb_empty_at_reset", sbq.size(), 0);
        reset       = 1'b1;
        btn_play    = 1'b0;
        btn_next    = 1'b0;
        player_done = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        prev_ts = 1'b0;
    endtask

    // Clean press; the event lands in cycle 6 after the rise, optionally with a done pulse.
    task automatic press(input logic p, input logic n, input logic d);
        btn_play = p;
        btn_next = n;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) player_done = d;
            tick();
        end
        player_done = 1'b0;
        btn_play    = 1'b0;
        btn_next    = 1'b0;
        repeat (7) tick();
    endtask

    task automatic done_pulse();
        player_done = 1'b1;
        tick();
        player_done = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [3:0] l, input int i, input logic e);
        check({name, "_led"}, 32'(led1), 32'(l));
        check({name, "_idx"}, 32'(idx1), 32'(i));
        check({name, "_base"}, 32'(base1), 32'(i * STRIDE));
        check({name, "_enable"}, 32'(en1), 32'(e));
    endtask

    initial begin
        int s0;
        tests       = 0;
        fails       = 0;
        starts0     = 0;
        prev_ts     = 1'b0;
        reset       = 1'b1;
        btn_play    = 1'b0;
        btn_next    = 1'b0;
        player_done = 1'b0;

        steps[0]  = '{A_PLAY,     4'b0010, 0, 1'b1, 1'b1};
        steps[1]  = '{A_DONE,     4'b1000, 0, 1'b0, 1'b0};
        steps[2]  = '{A_GAPWAIT,  4'b0010, 1, 1'b1, 1'b1};
        steps[3]  = '{A_NEXT,     4'b0010, 2, 1'b1, 1'b1};
        steps[4]  = '{A_NEXT,     4'b0010, 0, 1'b1, 1'b1};
        steps[5]  = '{A_PLAY,     4'b0100, 0, 1'b0, 1'b0};
        steps[6]  = '{A_DONE,     4'b0100, 0, 1'b0, 1'b0};
        steps[7]  = '{A_PLAY,     4'b0010, 0, 1'b1, 1'b0};
        steps[8]  = '{A_NEXT,     4'b0010, 1, 1'b1, 1'b1};
        steps[9]  = '{A_NEXTDONE, 4'b0010, 2, 1'b1, 1'b1};
        steps[10] = '{A_DONE,     4'b1000, 2, 1'b0, 1'b0};
        steps[11] = '{A_PLAY,     4'b0001, 2, 1'b0, 1'b0};
        steps[12] = '{A_NEXT,     4'b0001, 0, 1'b0, 1'b0};
        steps[13] = '{A_PLAY,     4'b0010, 0, 1'b1, 1'b1};
        steps[14] = '{A_PLAY,     4'b0100, 0, 1'b0, 1'b0};
        steps[15] = '{A_NEXT,     4'b0010, 1, 1'b1, 1'b1};

        do_reset();
        check_state("reset", 4'b0001, 0, 1'b0);
        check("reset_start", 32'(ts1), 0);
        check("reset_noloop_led", 32'(led0), 1);
        check("reset_noloop_idx", 32'(idx0), 0);

        // Press latency: event in cycle 6, track_start in cycle 7.
        expect_start(0);
        btn_play = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t1_start_c%0d", c), 32'(ts1), 32'(c == 7));
            if (c == 7) begin
                check("t1_base", 32'(base1), 0);
                check("t1_enable", 32'(en1), 1);
                check("t1_led", 32'(led1), 2);
            end
            tick();
        end
        btn_play = 1'b0;
        repeat (7) tick();
        check_state("t1_playing", 4'b0010, 0, 1'b1);

        // Short glitch must not produce a press.
        do_reset();
        btn_play = 1'b1;
        repeat (3) tick();
        btn_play = 1'b0;
        repeat (15) tick();
        check_state("t2_glitch", 4'b0001, 0, 1'b0);

        do_reset();
        for (int s = 0; s < 16; s++) begin
            if (steps[s].start) expect_start(steps[s].idx);
            case (steps[s].act)
                A_PLAY:     press(1'b1, 1'b0, 1'b0);
                A_NEXT:     press(1'b0, 1'b1, 1'b0);
                A_DONE:     done_pulse();
                A_NEXTDONE: press(1'b0, 1'b1, 1'b1);
                default:    repeat (GAPC + 2) tick();
            endcase
            check_state($sformatf("step%0d", s), steps[s].led, steps[s].idx, steps[s].en);
        end

        // Gap length: exactly GAPC cycles of GAP, then track_start on idx 2.
        expect_start(2);
        done_pulse();
        for (int g = 0; g < GAPC; g++) begin
            check($sformatf("t3_gap_led_g%0d", g), 32'(led1), 8);
            check($sformatf("t3_gap_start_g%0d", g), 32'(ts1), 0);
            tick();
        end
        check("t3_start", 32'(ts1), 1);
        check("t3_idx", 32'(idx1), 2);
        check("t3_base", 32'(base1), 512);

        // LOOP=0: gap expiry on the last track returns to IDLE at index 0.
        do_reset();
        expect_start(0);
        press(1'b1, 1'b0, 1'b0);
        expect_start(1);
        press(1'b0, 1'b1, 1'b0);
        expect_start(2);
        press(1'b0, 1'b1, 1'b0);
        check("t4_noloop_idx2", 32'(idx0), 2);
        done_pulse();
        expect_start(0);
        s0 = starts0;
        repeat (GAPC) tick();
        check("t4_noloop_led", 32'(led0), 1);
        check("t4_noloop_idx", 32'(idx0), 0);
        check("t4_noloop_base", 32'(base0), 0);
        check("t4_noloop_enable", 32'(en0), 0);
        check("t4_noloop_start", 32'(ts0), 0);
        check("t4_loop_wrap_start", 32'(ts1), 1);
        repeat (5) tick();
        check("t4_noloop_no_start", starts0, s0);

        // Reset in the middle of a gap.
        tick();
        done_pulse();
        repeat (4) tick();
        check("t6_in_gap", 32'(led1), 8);
        reset = 1'b1;
        tick();
        check_state("t6_reset", 4'b0001, 0, 1'b0);
        check("t6_reset_start", 32'(ts1), 0);
        reset = 1'b0;
        repeat (GAPC + 2) tick();
        check_state("t6_after_reset", 4'b0001, 0, 1'b0);

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
